// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU priority, DMA forced into short bursts after STARVE_MAX denials.
// Grants and memory drive are combinational; read data returns next cycle; a losing CPU sees cpu_stall_o.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int BURST      = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_stall_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_rvalid_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic              dma_rvalid_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic {NORMAL = 1'b0, DMA_BURST = 1'b1} state_e;

   localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
   localparam logic [2:0] BURST_C      = 3'(BURST);

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [2:0]  beat_q, beat_d;
   logic        cpu_rd_q, cpu_rd_d;
   logic        dma_rd_q, dma_rd_d;
   logic        cpu_gnt, dma_gnt;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (state_q == DMA_BURST && dma_req_i && beat_q < BURST_C) begin
         dma_gnt = 1'b1;
         beat_d  = beat_q + 3'd1;
      end else if (dma_req_i && starve_q == STARVE_MAX_C) begin
         // Starvation limit reached: this cycle is the first beat of a forced burst.
         dma_gnt = 1'b1;
         state_d = DMA_BURST;
         beat_d  = 3'd1;
      end else begin
         state_d = NORMAL;
         beat_d  = 3'd0;
         cpu_gnt = cpu_req_i;
         dma_gnt = dma_req_i & ~cpu_req_i;
      end
      if (!rst_ni) begin
         cpu_gnt = 1'b0;
         dma_gnt = 1'b0;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (dma_gnt || !dma_req_i) begin
         starve_d = 4'd0;
      end else if (starve_q != STARVE_MAX_C) begin
         starve_d = starve_q + 4'd1;
      end
      cpu_rd_d = cpu_gnt & ~cpu_we_i;
      dma_rd_d = dma_gnt & ~dma_we_i;
   end

   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (cpu_gnt) begin
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end else if (dma_gnt) begin
         mem_we_o    = dma_we_i;
         mem_addr_o  = dma_addr_i;
         mem_wdata_o = dma_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= NORMAL;
         starve_q <= 4'd0;
         beat_q   <= 3'd0;
         cpu_rd_q <= 1'b0;
         dma_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         beat_q   <= beat_d;
         cpu_rd_q <= cpu_rd_d;
         dma_rd_q <= dma_rd_d;
      end
   end

   assign mem_en_o     = cpu_gnt | dma_gnt;
   assign dma_gnt_o    = dma_gnt;
   assign cpu_stall_o  = cpu_req_i & ~cpu_gnt;
   assign cpu_rvalid_o = cpu_rd_q;
   assign dma_rvalid_o = dma_rd_q;
   // Read data is gated by the owner tag so every output is quiet while reset holds the tag empty.
   assign cpu_rdata_o  = cpu_rd_q ? mem_rdata_i : '0;
   assign dma_rdata_o  = dma_rd_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
   localparam int BURST      = 2;

   logic              clk_i;
   logic              rst_ni;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall_o, cpu_rvalid_o;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              dma_req, dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt_o, dma_rvalid_o;
   logic [DATA_W-1:0] dma_rdata_o;
   logic              mem_en_o, mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata;

   int vectors;
   int miscompares;

   // reference model state
   int          streak;
   int          forced_left;
   bit          pend_cpu, pend_dma;
   logic [31:0] pend_data;
   logic [31:0] ref_mem [256];
   bit          last_stall;

   // environment memory
   logic [31:0] env_mem [256];
   bit          env_init;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .BURST(BURST)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_stall_o(cpu_stall_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
      .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
      .dma_gnt_o(dma_gnt_o), .dma_rdata_o(dma_rdata_o), .dma_rvalid_o(dma_rvalid_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] init_val(input int i);
      logic [31:0] v;
      v = (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A5_0F0F;
      return v;
   endfunction

   always @(posedge clk_i) begin
      if (!env_init) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
         env_init <= 1'b1;
      end else if (mem_en_o) begin
         if (mem_we_o) env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
         else          mem_rdata <= env_mem[mem_addr_o[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      streak      = 0;
      forced_left = 0;
      pend_cpu    = 1'b0;
      pend_dma    = 1'b0;
      last_stall  = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, check combinational and returned-read outputs, advance the model.
   task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
      bit          eg_cpu, eg_dma, e_we;
      logic [31:0] e_addr, e_wd;
      @(negedge clk_i);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      #1;
      eg_cpu = 1'b0;
      eg_dma = 1'b0;
      if (forced_left > 0 && dr) begin
         eg_dma = 1'b1;
         forced_left--;
      end else begin
         forced_left = 0;
         if (dr && streak >= STARVE_MAX) begin
            eg_dma      = 1'b1;
            forced_left = BURST - 1;
         end else begin
            eg_cpu = cr;
            eg_dma = dr && !cr;
         end
      end
      e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (eg_cpu)      begin e_we = cw; e_addr = ca; e_wd = cd; end
      else if (eg_dma) begin e_we = dw; e_addr = da; e_wd = dd; end

      chk("dma_gnt",    dma_gnt_o,    eg_dma);
      chk("mem_en",     mem_en_o,     eg_cpu | eg_dma);
      chk("mem_we",     mem_we_o,     e_we);
      chk("mem_addr",   mem_addr_o,   e_addr);
      chk("mem_wdata",  mem_wdata_o,  e_wd);
      chk("cpu_stall",  cpu_stall_o,  cr && !eg_cpu);
      chk("cpu_rvalid", cpu_rvalid_o, pend_cpu);
      chk("dma_rvalid", dma_rvalid_o, pend_dma);
      if (pend_cpu) chk("cpu_rdata", cpu_rdata_o, pend_data);
      if (pend_dma) chk("dma_rdata", dma_rdata_o, pend_data);

      streak     = (dr && !eg_dma) ? ((streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1) : 0;
      pend_cpu   = eg_cpu && !cw;
      pend_dma   = eg_dma && !dw;
      if ((eg_cpu || eg_dma) && !e_we) pend_data = ref_mem[e_addr[7:0]];
      if ((eg_cpu || eg_dma) && e_we)  ref_mem[e_addr[7:0]] = e_wd;
      last_stall = cr && !eg_cpu;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      bit          r_cr, r_cw, r_dr, r_dw;
      logic [31:0] r_ca, r_cd, r_da, r_dd;
      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      model_reset();

      // reset: outputs quiet, stall follows cpu_req
      rst_ni = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h99;
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_dma_gnt",    dma_gnt_o,    1'b0);
      chk("rst_mem_en",     mem_en_o,     1'b0);
      chk("rst_mem_we",     mem_we_o,     1'b0);
      chk("rst_mem_addr",   mem_addr_o,   32'h0);
      chk("rst_mem_wdata",  mem_wdata_o,  32'h0);
      chk("rst_cpu_rvalid", cpu_rvalid_o, 1'b0);
      chk("rst_dma_rvalid", dma_rvalid_o, 1'b0);
      chk("rst_cpu_rdata",  cpu_rdata_o,  32'h0);
      chk("rst_dma_rdata",  dma_rdata_o,  32'h0);
      chk("rst_stall_hi",   cpu_stall_o,  1'b1);
      cpu_req = 1'b0;
      #1;
      chk("rst_stall_lo",   cpu_stall_o,  1'b0);
      @(negedge clk_i);
      dma_req = 1'b0; cpu_req = 1'b0;
      rst_ni = 1'b1;

      // CPU read of 0x10
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("cpu_rd_en", mem_en_o, 1'b1);
      chk("cpu_rd_stall", cpu_stall_o, 1'b0);
      idle();
      chk("cpu_rd_valid", cpu_rvalid_o, 1'b1);
      chk("cpu_rd_data", cpu_rdata_o, 32'hDEADBEEF);

      // DMA write then read back
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);
      chk("dma_wr_gnt", dma_gnt_o, 1'b1);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk("dma_rd_gnt", dma_gnt_o, 1'b1);
      idle();
      chk("dma_rd_valid", dma_rvalid_o, 1'b1);
      chk("dma_rd_data", dma_rdata_o, 32'h55);

      // continuous contention: four CPU grants then a two-beat DMA burst
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 1'b0, 32'(k), 32'h0, 1'b1, 1'b0, 32'(k + 3), 32'h0);
         chk("pattern", dma_gnt_o, (k % 6) >= 4);
      end

      // forced burst abandoned after first beat
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 32'(40 + k), 32'(k), 1'b1, 1'b0, 32'h5, 32'h0);
      chk("forced_beat", dma_gnt_o, 1'b1);
      step(1'b1, 1'b0, 32'h7, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("drop_cpu_gnt", cpu_stall_o, 1'b0);
      chk("drop_dma_gnt", dma_gnt_o, 1'b0);

      // CPU write beats DMA read; starvation count advances by exactly one
      idle();
      step(1'b1, 1'b1, 32'h30, 32'hCAFE, 1'b1, 1'b0, 32'h31, 32'h0);
      chk("cw_dr_gnt", dma_gnt_o, 1'b0);
      chk("cw_dr_we", mem_we_o, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h31, 32'h0);
         chk("starve_plus1", dma_gnt_o, k == 3);
      end
      idle();

      // reset between read grant and its return
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("rst_drop_rvalid", cpu_rvalid_o, 1'b0);
      @(negedge clk_i);
      cpu_req = 1'b0; dma_req = 1'b0;
      rst_ni = 1'b1;
      model_reset();
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0, 32'h2, 32'h0);
         chk("post_rst_pattern", dma_gnt_o, k >= 4);
      end

      // random traffic; a stalled CPU holds its request
      r_cr = 1'b0; r_cw = 1'b0; r_ca = '0; r_cd = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!last_stall) begin
            r_cr = ($urandom_range(0, 9) < 7);
            r_cw = $urandom_range(0, 1) != 0;
            r_ca = 32'($urandom_range(0, 31));
            r_cd = $urandom;
         end
         r_dr = ($urandom_range(0, 9) < 7);
         r_dw = $urandom_range(0, 1) != 0;
         r_da = 32'($urandom_range(0, 31));
         r_dd = $urandom;
         step(r_cr, r_cw, r_ca, r_cd, r_dr, r_dw, r_da, r_dd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
